// File: rtl/board_pkg.sv
// Shared encodings for the NxN board renderer: cell codes, winner codes,
// scanner states and the cell bit-offset helper.
package board_pkg;
  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_P1    = 2'b01;
  localparam logic [1:0] C_P2    = 2'b10;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_P1    = 2'b01;
  localparam logic [1:0] W_P2    = 2'b10;
  localparam logic [1:0] W_DRAW  = 2'b11;

  // Line index width: covers 2N+1 for N up to 8.
  localparam int KW = 5;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_st_e;

  // LSB of cell (r,c) in a row-major, MSB-first board vector.
  function automatic int cell_lsb(input int n, input int r, input int c);
    return 2 * (n * n - 1 - (r * n + c));
  endfunction
endpackage

// File: rtl/board_win_scan.sv
// Per-frame board snapshot plus a one-line-per-cycle win/draw scanner.
module board_win_scan
  import board_pkg::*;
#(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_start,
  input  logic [2*N*N-1:0]   i_square,
  output logic [2*N*N-1:0]   o_snap,
  output logic [1:0]         o_winner,
  output logic [KW-1:0]      o_win_line,
  output logic               o_result_valid
);
  scan_st_e            r_st;
  logic [2*N*N-1:0]    r_snap;
  logic [KW-1:0]       r_k, r_line, r_win_line;
  logic                r_found, r_valid;
  logic [1:0]          r_who, r_winner;
  logic                w_win, w_full;
  logic [1:0]          w_first;

  // Evaluate line r_k: rows, then columns, then main and anti diagonal.
  always_comb begin
    int kk, rr, cc;
    logic [1:0] v;
    logic eq;
    kk = {{(32-KW){1'b0}}, r_k};
    rr = 0;
    cc = 0;
    v = C_EMPTY;
    eq = 1'b1;
    w_first = C_EMPTY;
    for (int i = 0; i < N; i++) begin
      if (kk < N) begin rr = kk; cc = i; end
      else if (kk < 2*N) begin rr = i; cc = kk - N; end
      else if (kk == 2*N) begin rr = i; cc = i; end
      else begin rr = i; cc = N - 1 - i; end
      v = r_snap[cell_lsb(N, rr, cc) +: 2];
      if (i == 0) w_first = v;
      else if (v != w_first) eq = 1'b0;
    end
    w_win = eq && (w_first == C_P1 || w_first == C_P2);
  end

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < N*N; i++)
      if (r_snap[2*i +: 2] == C_EMPTY || r_snap[2*i +: 2] == 2'b11) w_full = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st       <= S_IDLE;
      r_snap     <= '0;
      r_k        <= '0;
      r_line     <= '0;
      r_found    <= 1'b0;
      r_who      <= W_NONE;
      r_winner   <= W_NONE;
      r_win_line <= '0;
      r_valid    <= 1'b0;
    end else if (i_frame_start) begin
      r_snap  <= i_square;
      r_st    <= S_SCAN;
      r_k     <= '0;
      r_found <= 1'b0;
      r_line  <= '0;
    end else begin
      case (r_st)
        S_SCAN: begin
          if (w_win && !r_found) begin
            r_found <= 1'b1;
            r_who   <= w_first;
            r_line  <= r_k;
          end
          if (r_k == KW'(2*N+1)) r_st <= S_DONE;
          else r_k <= r_k + 1'b1;
        end
        S_DONE: begin
          r_winner   <= r_found ? r_who : (w_full ? W_DRAW : W_NONE);
          r_win_line <= r_line;
          r_valid    <= 1'b1;
          r_st       <= S_IDLE;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign o_snap         = r_snap;
  assign o_winner       = r_winner;
  assign o_win_line     = r_win_line;
  assign o_result_valid = r_valid;
endmodule

// File: rtl/board_render_grid.sv
// NxN board renderer: 2-stage pixel pipeline (decode, colour) with a blinking
// winning line, fed by a tear-free snapshot scanner.
module board_render_grid
  import board_pkg::*;
#(
  parameter int N            = 3,
  parameter int CELL         = 160,
  parameter int LINE_W       = 20,
  parameter int MARK_HALF    = 50,
  parameter int CUR_HALF     = 10,
  parameter int BLINK_FRAMES = 30,
  parameter int CW           = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [9:0]         cursor_x,
  input  logic [9:0]         cursor_y,
  input  logic [2*N*N-1:0]   square,
  output logic [CW-1:0]      red,
  output logic [CW-1:0]      green,
  output logic [CW-1:0]      blue,
  output logic [1:0]         winner,
  output logic               result_valid
);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [2*N*N-1:0] w_snap;
  logic [1:0]       w_winner;
  logic [KW-1:0]    w_win_line;

  board_win_scan #(.N(N)) u_scan (
    .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start), .i_square(square),
    .o_snap(w_snap), .o_winner(w_winner), .o_win_line(w_win_line),
    .o_result_valid(result_valid)
  );

  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (frame_start) begin
      if (r_bcnt == BW'(BLINK_FRAMES-1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else r_bcnt <= r_bcnt + 1'b1;
    end
  end

  // Cursor distance in signed 11 bits so a cursor near 0 cannot wrap.
  logic signed [10:0] w_dx, w_dy, w_ax, w_ay;
  logic               w_cur, w_mark, w_grid, w_ind;
  logic [2:0]         w_row, w_col;
  logic [1:0]         w_cell;

  assign w_dx  = $signed({1'b0, x}) - $signed({1'b0, cursor_x});
  assign w_dy  = $signed({1'b0, y}) - $signed({1'b0, cursor_y});
  assign w_ax  = w_dx[10] ? -w_dx : w_dx;
  assign w_ay  = w_dy[10] ? -w_dy : w_dy;
  assign w_cur = (w_ax < $signed(11'(CUR_HALF))) && (w_ay < $signed(11'(CUR_HALF)));

  // Cell index by compare chain against k*CELL; no divider.
  always_comb begin
    int xi, yi, col, row, ox, oy;
    xi = {22'd0, x};
    yi = {22'd0, y};
    col = 0;
    row = 0;
    w_grid = 1'b0;
    for (int k = 1; k < N; k++) begin
      if (xi >= k*CELL) col = k;
      if (yi >= k*CELL) row = k;
      if (yi < N*CELL && xi > k*CELL - LINE_W/2 && xi < k*CELL + LINE_W/2) w_grid = 1'b1;
      if (xi < N*CELL && yi > k*CELL - LINE_W/2 && yi < k*CELL + LINE_W/2) w_grid = 1'b1;
    end
    ox = xi - col*CELL - CELL/2;
    oy = yi - row*CELL - CELL/2;
    w_mark = (xi < N*CELL) && (yi < N*CELL) && (ox > -MARK_HALF) && (ox < MARK_HALF)
             && (oy > -MARK_HALF) && (oy < MARK_HALF);
    w_ind  = (xi >= N*CELL) && (xi < N*CELL + 80) && (yi >= 70) && (yi < 100);
    w_col  = 3'(col);
    w_row  = 3'(row);
    w_cell = w_snap[cell_lsb(N, row, col) +: 2];
  end

  logic       r1_cur, r1_mark, r1_grid, r1_ind;
  logic [2:0] r1_row, r1_col;
  logic [1:0] r1_cell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r1_cur, r1_mark, r1_grid, r1_ind} <= '0;
      r1_row  <= '0;
      r1_col  <= '0;
      r1_cell <= C_EMPTY;
    end else begin
      {r1_cur, r1_mark, r1_grid, r1_ind} <= {w_cur, w_mark, w_grid, w_ind};
      r1_row  <= w_row;
      r1_col  <= w_col;
      r1_cell <= w_cell;
    end
  end

  logic          w_on_line;
  logic [CW-1:0] w_r, w_g, w_b;

  always_comb begin
    int wl, rr, cc;
    wl = {{(32-KW){1'b0}}, w_win_line};
    rr = {29'd0, r1_row};
    cc = {29'd0, r1_col};
    if (wl < N)         w_on_line = (rr == wl);
    else if (wl < 2*N)  w_on_line = (cc == wl - N);
    else if (wl == 2*N) w_on_line = (rr == cc);
    else                w_on_line = (rr + cc == N - 1);
    w_on_line = w_on_line && (w_winner == W_P1 || w_winner == W_P2);
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (r1_cur) begin
      w_r = '1; w_g = '1; w_b = '1;
    end else if (r1_mark && (r1_cell == C_P1 || r1_cell == C_P2)) begin
      if (w_on_line && r_phase) begin w_r = '1; w_g = '1; w_b = '1; end
      else if (r1_cell == C_P1) w_r = '1;
      else w_g = '1;
    end else if (r1_grid) begin
      w_r = '1; w_g = '1; w_b = '1;
    end else if (r1_ind) begin
      if (w_winner == W_P1) w_r = '1;
      else if (w_winner == W_P2) w_g = '1;
      else if (w_winner == W_DRAW) w_b = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= w_r;
      green <= w_g;
      blue  <= w_b;
    end
  end

  assign winner = w_winner;
endmodule

// File: tb/tb_board_render_grid.sv
// Scoreboard bench for board_render_grid (N=3): winner/latency per frame and
// 2-cycle pixel colours checked against hand-derived expectations.
module tb_board_render_grid;
  logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  logic [9:0]  x = '0, y = '0, cursor_x = 10'd1000, cursor_y = 10'd1000;
  logic [17:0] square = '0;
  logic [9:0]  red, green, blue;
  logic [1:0]  winner;
  logic        result_valid;

  board_render_grid u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .x(x), .y(y),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .square(square),
    .red(red), .green(green), .blue(blue), .winner(winner), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0, nfs = 0;

  localparam logic [29:0] BLK = 30'h0;
  localparam logic [29:0] RED = {10'h3FF, 20'h0};
  localparam logic [29:0] GRN = {10'h0, 10'h3FF, 10'h0};
  localparam logic [29:0] BLU = {20'h0, 10'h3FF};
  localparam logic [29:0] WHT = {30{1'b1}};

  typedef struct { int due; logic [29:0] rgb; string tag; } pexp_t;
  typedef struct { logic [1:0] w; logic [4:0] line; string tag; } wexp_t;
  pexp_t pq[$];
  wexp_t wq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] bd(input string s);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++)
      case (s[i])
        "1": b[17-2*i -: 2] = 2'b01;
        "2": b[17-2*i -: 2] = 2'b10;
        "3": b[17-2*i -: 2] = 2'b11;
        default: b[17-2*i -: 2] = 2'b00;
      endcase
    return b;
  endfunction

  // P1 mark colour given the frame pulses seen so far (blink every 30).
  function automatic logic [29:0] p1c();
    return ((nfs / 30) % 2) ? WHT : RED;
  endfunction

  always @(negedge clk) begin
    pexp_t e;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      chk(e.tag, 32'({red, green, blue}), 32'(e.rgb));
    end
  end

  task automatic px(input int xx, input int yy, input logic [29:0] rgb, input string tag);
    x = 10'(xx);
    y = 10'(yy);
    pq.push_back('{cyc + 2, rgb, tag});
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && pq.size() > 0; i++) @(negedge clk);
    if (pq.size() > 0) begin
      chk("drain", 32'(pq.size()), 32'd0);
      pq.delete();
    end
  endtask

  task automatic pulse(input logic [17:0] b);
    square = b;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    nfs++;
  endtask

  task automatic frame(input logic [17:0] b, input logic [1:0] w, input logic [4:0] ln,
                       input string tag);
    logic [1:0] ow;
    logic ov;
    wexp_t e;
    ow = winner;
    ov = result_valid;
    wq.push_back('{w, ln, tag});
    pulse(b);
    repeat (8) @(negedge clk);
    chk({tag, "_hold"}, 32'(winner), 32'(ow));
    chk({tag, "_vhold"}, 32'(result_valid), 32'(ov));
    @(negedge clk);
    e = wq.pop_front();
    chk({tag, "_win"}, 32'(winner), 32'(e.w));
    chk({tag, "_line"}, 32'(u_dut.w_win_line), 32'(e.line));
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    x = 10'd150;
    y = 10'd0;
    repeat (4) @(negedge clk);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    frame(bd("........."), 2'b00, 5'd0, "empty");
    frame(bd("111......"), 2'b01, 5'd0, "row0");
    px(80, 80, p1c(), "mark00");
    px(31, 80, p1c(), "mark_edge_in");
    px(30, 80, BLK, "mark_edge_out");
    px(240, 240, BLK, "empty_cell");
    px(520, 80, RED, "ind_p1");
    px(559, 99, RED, "ind_corner");
    px(480, 70, RED, "ind_origin");
    px(480, 69, BLK, "ind_above");
    px(479, 80, BLK, "ind_left");
    px(160, 10, WHT, "grid_v");
    px(169, 10, WHT, "grid_v_edge");
    px(170, 10, BLK, "grid_v_out");
    px(10, 160, WHT, "grid_h");
    px(160, 480, BLK, "grid_below");
    drain();

    square = '0;
    repeat (3) @(negedge clk);
    px(80, 80, p1c(), "tear_mark");
    drain();
    chk("tear_winner", 32'(winner), 32'd1);

    frame(bd("..2.2.2.."), 2'b10, 5'd7, "anti");
    px(520, 80, GRN, "ind_p2");
    px(400, 80, GRN, "mark02_p2");
    drain();
    frame(bd("222...111"), 2'b10, 5'd0, "order_rows");
    frame(bd("1..1..111"), 2'b01, 5'd2, "order_rowcol");
    frame(bd("121112212"), 2'b11, 5'd0, "draw");
    px(520, 80, BLU, "ind_draw");
    drain();
    frame(bd("121112213"), 2'b00, 5'd0, "cell11");
    px(520, 80, BLK, "ind_none");
    drain();

    pulse(bd("222......"));
    repeat (2) @(negedge clk);
    frame(bd("1..1..1.."), 2'b01, 5'd3, "restart");

    frame(bd("111......"), 2'b01, 5'd0, "row0b");
    cursor_x = 10'd80;
    cursor_y = 10'd80;
    px(80, 80, WHT, "cursor");
    px(89, 71, WHT, "cursor_edge");
    px(90, 80, p1c(), "cursor_out");
    cursor_x = 10'd5;
    px(1020, 80, BLK, "cursor_nowrap");
    px(0, 80, WHT, "cursor_low");
    drain();
    cursor_x = 10'd1000;
    cursor_y = 10'd1000;

    while (nfs < 64) begin
      pulse(bd("111......"));
      px(80, 80, p1c(), $sformatf("blink_f%0d", nfs));
      drain();
    end
    chk("blink_winner", 32'(winner), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
